compensation_accumulator_controller: RTL and testbench

COMPENSATION_ACCUMULATOR_CONTROLLER -- requirements
Module: compensation_accumulator_controller

---
 rtl/compensation_accumulator_controller_pkg.sv | 21 ++
 rtl/compensation_accumulator_controller_index_counter.sv | 63 ++++++
 rtl/compensation_accumulator_controller.sv | 152 +++++++++++++++
 tb/tb_compensation_accumulator_controller.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compensation_accumulator_controller_pkg.sv
// Shared definitions for the compensation accumulator controller.
// Holds the controller FSM state encoding, the default accumulator
// depth, the partial-sum width used by the datapath, and a helper that
// sizes the entry index so a depth of 1 still yields a legal 1-bit index.
package compensation_accumulator_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } cacc_state_e;

  localparam int CACC_DEPTH_DEFAULT             = 8;
  localparam int COMPENSATION_PARTIAL_SUM_WIDTH = 32;

  function automatic int cacc_idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/compensation_accumulator_controller_index_counter.sv
// cacc_index_counter: entry and tile position of the next accumulator write.
// Ports:
//   clk, rst        - clock, synchronous active-low reset
//   clear           - restart both counters at zero (new job or abort)
//   advance         - one write consumed the current position
//   num_tiles       - latched tile count of the running job
//   entry_idx       - entry (column) index of the next write
//   tile_idx        - tile index of the next write
//   entry_last      - next write is the last entry of a tile
//   job_last        - next write is the last entry of the last tile
module cacc_index_counter
  import compensation_accumulator_controller_pkg::*;
#(
  parameter int DEPTH  = CACC_DEPTH_DEFAULT,
  parameter int TILE_W = 8,
  parameter int COL_W  = cacc_idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic [TILE_W-1:0] num_tiles,
  output logic [COL_W-1:0]  entry_idx,
  output logic [TILE_W-1:0] tile_idx,
  output logic              entry_last,
  output logic              job_last
);

  logic [COL_W-1:0]  entry_r;
  logic [TILE_W-1:0] tile_r;

  assign entry_last = (entry_r == COL_W'(DEPTH - 1));
  assign job_last   = entry_last & (tile_r == (num_tiles - TILE_W'(1)));
  assign entry_idx  = entry_r;
  assign tile_idx   = tile_r;

  // Step through entries; a tile wrap bumps the tile, and the final write
  // of the job parks the tile at zero so it never reaches num_tiles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      entry_r <= '0;
      tile_r  <= '0;
    end else if (clear) begin
      entry_r <= '0;
      tile_r  <= '0;
    end else if (advance) begin
      if (entry_last) begin
        entry_r <= '0;
        if (job_last) begin
          tile_r <= '0;
        end else begin
          tile_r <= tile_r + TILE_W'(1);
        end
      end else begin
        entry_r <= entry_r + COL_W'(1);
      end
    end else begin
      entry_r <= entry_r;
      tile_r  <= tile_r;
    end
  end

endmodule

// File: rtl/compensation_accumulator_controller.sv
// compensation_accumulator_controller: sequences compensation sums from the
// systolic array into the accumulator shift register, one tile of DEPTH
// entries at a time, and tags each sum at the accumulator head.
// Ports:
//   clk, rst                      - clock, synchronous active-low reset
//   start, num_tiles              - job request and its tile count (IDLE only)
//   abort                         - cancel the job, highest priority
//   comp_valid / comp_ready       - handshake with the systolic array
//   CACC_Write_enable             - accumulator shift enable
//   out_valid / out_ready         - accumulator head handshake downstream
//   col_idx, tile_idx, tile_last  - tags of the sum at the head
//   busy, done                    - job in progress / one-cycle completion
module compensation_accumulator_controller
  import compensation_accumulator_controller_pkg::*;
#(
  parameter  int DEPTH  = CACC_DEPTH_DEFAULT,
  parameter  int TILE_W = 8,
  localparam int COL_W  = cacc_idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic              abort,
  input  logic              comp_valid,
  output logic              comp_ready,
  output logic              CACC_Write_enable,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COL_W-1:0]  col_idx,
  output logic [TILE_W-1:0] tile_idx,
  output logic              tile_last,
  output logic              busy,
  output logic              done
);

  cacc_state_e       state_r;
  logic [TILE_W-1:0] num_tiles_r;
  logic              out_valid_r;
  logic [COL_W-1:0]  col_idx_r;
  logic [TILE_W-1:0] tile_idx_r;
  logic              tile_last_r;
  logic              done_r;

  logic              comp_ready_s;
  logic              wr_en_s;
  logic              start_accept_s;
  logic              cnt_clear_s;
  logic [COL_W-1:0]  entry_s;
  logic [TILE_W-1:0] tile_s;
  logic              entry_last_s;
  logic              job_last_s;

  // The head may only be shifted when it is empty or being consumed now.
  assign comp_ready_s   = (state_r == ST_ACCEPT) & (~out_valid_r | out_ready);
  // Abort and reset suppress the shift in the very cycle they are raised.
  assign wr_en_s        = comp_valid & comp_ready_s & ~abort & rst;
  assign start_accept_s = (state_r == ST_IDLE) & start & (num_tiles != TILE_W'(0)) & ~abort;
  assign cnt_clear_s    = abort | start_accept_s;

  cacc_index_counter #(
    .DEPTH  (DEPTH),
    .TILE_W (TILE_W),
    .COL_W  (COL_W)
  ) u_index_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear_s),
    .advance    (wr_en_s),
    .num_tiles  (num_tiles_r),
    .entry_idx  (entry_s),
    .tile_idx   (tile_s),
    .entry_last (entry_last_s),
    .job_last   (job_last_s)
  );

  // Job FSM together with the accumulator-head tag register and done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      num_tiles_r <= '0;
      out_valid_r <= 1'b0;
      col_idx_r   <= '0;
      tile_idx_r  <= '0;
      tile_last_r <= 1'b0;
      done_r      <= 1'b0;
    end else if (abort) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      tile_last_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (wr_en_s) begin
        out_valid_r <= 1'b1;
        col_idx_r   <= entry_s;
        tile_idx_r  <= tile_s;
        tile_last_r <= entry_last_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
        tile_last_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (start_accept_s) begin
            num_tiles_r <= num_tiles;
            state_r     <= ST_ACCEPT;
          end else if (start) begin
            // Empty job: complete immediately without touching the accumulator.
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCEPT: begin
          if (wr_en_s && job_last_s) begin
            state_r <= ST_DRAIN;
          end else begin
            state_r <= ST_ACCEPT;
          end
        end
        ST_DRAIN: begin
          if (!out_valid_r || out_ready) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign comp_ready        = comp_ready_s;
  assign CACC_Write_enable = wr_en_s;
  assign out_valid         = out_valid_r;
  assign col_idx           = col_idx_r;
  assign tile_idx          = tile_idx_r;
  assign tile_last         = tile_last_r;
  assign busy              = (state_r != ST_IDLE);
  assign done              = done_r;

endmodule

// File: tb/tb_compensation_accumulator_controller.sv
// Self-checking bench for compensation_accumulator_controller.
// Expected head sums for a job are the full (entry, tile) sweep pushed into
// a queue at start; a monitor pops one entry per out_valid/out_ready
// handshake and also tracks writes and done pulses.
module tb_compensation_accumulator_controller;

  localparam int DEPTH  = 8;
  localparam int TILE_W = 8;
  localparam int COL_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [TILE_W-1:0] num_tiles = '0;
  logic              abort = 1'b0;
  logic              comp_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              comp_ready;
  logic              CACC_Write_enable;
  logic              out_valid;
  logic [COL_W-1:0]  col_idx;
  logic [TILE_W-1:0] tile_idx;
  logic              tile_last;
  logic              busy;
  logic              done;

  compensation_accumulator_controller #(.DEPTH(DEPTH), .TILE_W(TILE_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .num_tiles         (num_tiles),
    .abort             (abort),
    .comp_valid        (comp_valid),
    .comp_ready        (comp_ready),
    .CACC_Write_enable (CACC_Write_enable),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .col_idx           (col_idx),
    .tile_idx          (tile_idx),
    .tile_last         (tile_last),
    .busy              (busy),
    .done              (done)
  );

  typedef struct packed {
    logic [COL_W-1:0]  col;
    logic [TILE_W-1:0] tile;
    logic              last;
  } item_t;

  item_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    exp_done_cyc = -1;
  int    wr_count = 0;
  int    done_count = 0;
  int    last_we_cyc = 0;
  bit    prev_we = 1'b0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a job of n tiles delivers every entry of tile 0, then tile 1, ...
  task automatic push_job(input int n);
    item_t it;
    for (int t = 0; t < n; t++) begin
      for (int e = 0; e < DEPTH; e++) begin
        it.col  = COL_W'(e);
        it.tile = TILE_W'(t);
        it.last = (e == DEPTH - 1);
        exp_q.push_back(it);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops, write latency, head protection, done timing.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (CACC_Write_enable) begin
        wr_count++;
        last_we_cyc = cyc;
        check("write_without_comp_valid", comp_valid, 1);
      end
      if (prev_we) check("write_to_out_valid_latency", out_valid, 1);
      prev_we = CACC_Write_enable;
      if (out_valid && !out_ready) check("comp_ready_while_head_held", comp_ready, 0);
      if (out_valid && out_ready && rst && !abort) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          it = exp_q.pop_front();
          check("col_idx", col_idx, it.col);
          check("tile_idx", tile_idx, it.tile);
          check("tile_last", tile_last, it.last);
          if (exp_q.size() == 0) exp_done_cyc = cyc + 1;
        end
      end
      if (exp_done_cyc == cyc) begin
        check("done_pulse", done, 1);
        exp_done_cyc = -1;
      end else if (done) begin
        check("unexpected_done", done, 0);
      end
      if (done) done_count++;
    end
  end

  // Wait (bounded) for the job's done, randomising handshakes if asked,
  // then check totals for the job.
  task automatic wait_job(input int d0, input int w0, input int n, input int s,
                          input bit rnd, input bit chk_span);
    int k;
    k = 0;
    @(negedge clk);
    #1;
    while (done_count == d0 && k < 3000) begin
      step();
      start = 1'b0;
      if (rnd) begin
        comp_valid = ($urandom_range(0, 3) != 0);
        out_ready  = ($urandom_range(0, 3) != 0);
        start      = ($urandom_range(0, 7) == 0);
        num_tiles  = TILE_W'($urandom_range(0, 5));
      end
      @(negedge clk);
      #1;
      k++;
    end
    check("done_count_per_job", done_count - d0, 1);
    check("writes_per_job", wr_count - w0, n * DEPTH);
    check("scoreboard_drained", exp_q.size(), 0);
    if (chk_span && n > 0) check("consecutive_writes_end", last_we_cyc, s + n * DEPTH);
    step();
    start      = 1'b0;
    comp_valid = 1'b0;
    out_ready  = 1'b1;
    #1;
    check("idle_after_job_busy", busy, 0);
  endtask

  task automatic run_job(input int n, input bit rnd);
    int d0, w0, s;
    d0 = done_count;
    w0 = wr_count;
    step();
    start      = 1'b1;
    num_tiles  = TILE_W'(n);
    comp_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    out_ready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    s = cyc;
    push_job(n);
    if (n == 0) exp_done_cyc = s + 1;
    wait_job(d0, w0, n, s, rnd, !rnd);
  endtask

  initial begin
    int d0, w0, k;
    // Reset state with comp_valid high.
    comp_valid = 1'b1;
    step();
    step();
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_comp_ready", comp_ready, 0);
    check("reset_write_enable", CACC_Write_enable, 0);
    rst        = 1'b1;
    comp_valid = 1'b0;
    out_ready  = 1'b1;
    step();

    // Two tiles, everything flowing: 16 back-to-back writes.
    run_job(2, 1'b0);

    // One tile, consumer stalls after the first write.
    d0 = done_count;
    w0 = wr_count;
    step();
    start      = 1'b1;
    num_tiles  = TILE_W'(1);
    comp_valid = 1'b1;
    out_ready  = 1'b0;
    push_job(1);
    step();
    start     = 1'b0;
    num_tiles = TILE_W'(7);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_comp_ready", comp_ready, 0);
      check("stall_write_enable", CACC_Write_enable, 0);
      check("stall_col_idx", col_idx, 0);
      check("stall_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    wait_job(d0, w0, 1, 0, 1'b0, 1'b0);

    // Empty job.
    run_job(0, 1'b0);

    // Abort at tile 1, entry 3 with comp_valid high.
    d0 = done_count;
    w0 = wr_count;
    step();
    start      = 1'b1;
    num_tiles  = TILE_W'(2);
    comp_valid = 1'b1;
    out_ready  = 1'b1;
    push_job(2);
    step();
    start = 1'b0;
    k = 0;
    @(negedge clk);
    #1;
    while (wr_count - w0 < 11 && k < 100) begin
      step();
      @(negedge clk);
      #1;
      k++;
    end
    check("abort_setup_writes", wr_count - w0, 11);
    step();
    abort = 1'b1;
    #1;
    check("abort_cycle_write_enable", CACC_Write_enable, 0);
    exp_q.delete();
    step();
    abort      = 1'b0;
    comp_valid = 1'b0;
    #1;
    check("after_abort_out_valid", out_valid, 0);
    check("after_abort_busy", busy, 0);
    check("after_abort_done", done, 0);
    repeat (3) step();
    check("abort_no_done", done_count - d0, 0);
    run_job(1, 1'b0);

    // Reset mid-ACCEPT, with a start issued while busy beforehand.
    d0 = done_count;
    step();
    start      = 1'b1;
    num_tiles  = TILE_W'(1);
    comp_valid = 1'b1;
    out_ready  = 1'b1;
    push_job(1);
    step();
    start = 1'b0;
    step();
    start     = 1'b1;
    num_tiles = TILE_W'(3);
    step();
    start = 1'b0;
    check("busy_ignores_start", busy, 1);
    step();
    rst = 1'b0;
    exp_q.delete();
    exp_done_cyc = -1;
    step();
    rst = 1'b1;
    #1;
    check("midjob_reset_out_valid", out_valid, 0);
    check("midjob_reset_busy", busy, 0);
    check("midjob_reset_done", done, 0);
    check("midjob_reset_comp_ready", comp_ready, 0);
    check("midjob_reset_write_enable", CACC_Write_enable, 0);
    comp_valid = 1'b0;
    repeat (3) step();
    check("reset_no_done", done_count - d0, 0);
    run_job(1, 1'b0);

    // Randomised jobs.
    for (int j = 0; j < 8; j++) begin
      run_job(int'($urandom_range(0, 3)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
